// File: rtl/bus_src_pipe_pkg.sv
// bus_src_pkg: shared select offsets, immediate modes and select-limit helper for bus_src_pipe
package bus_src_pkg;

    localparam int SEL_G_OFS    = 0;
    localparam int SEL_IMM_OFS  = 1;
    localparam int SEL_IMMH_OFS = 2;
    localparam int SEL_SEXT_OFS = 3;

    typedef enum logic [1:0] {
        IMM_ZEXT = 2'd0,
        IMM_HIGH = 2'd1,
        IMM_SEXT = 2'd2
    } imm_mode_e;

    function automatic int sel_limit(input int num_regs);
        return num_regs + SEL_SEXT_OFS + 1;
    endfunction

endpackage

// File: rtl/bus_src_pipe_if.sv
// bus_src_pipe_if: request/response handshake bundle between bus source and consumers
interface bus_src_pipe_if #(
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;

    modport master (
        output in_valid, sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/bus_src_pipe_imm_extract.sv
// imm_extract: forms zero-extended, load-high or sign-extended immediates from IR
module imm_extract
    import bus_src_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IMM_W  = 9
) (
    input  logic [DATA_W-1:0] ir,
    input  imm_mode_e         mode,
    output logic [DATA_W-1:0] imm
);
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] high;
    logic [DATA_W-1:0] sext;
    logic              unused_ir;

    assign zext      = DATA_W'(ir[IMM_W-1:0]);
    assign high      = {ir[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
    assign sext      = DATA_W'($signed(ir[IMM_W-1:0]));
    assign imm       = mode == IMM_SEXT ? sext : mode == IMM_HIGH ? high : zext;
    assign unused_ir = ^ir;
endmodule

// File: rtl/bus_src_pipe.sv
// bus_src_pipe: pipelined bus-source mux with valid/ready handshake; BUS_SRC_ERR_EN adds sticky sel_err/err_clr
module bus_src_pipe
    import bus_src_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int IMM_W    = 9,
    parameter int SEL_W    = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NUM_REGS*DATA_W-1:0] regs,
    input  logic [DATA_W-1:0]          ir,
    input  logic [DATA_W-1:0]          greg,
    bus_src_pipe_if.slave              bus,
`ifdef BUS_SRC_ERR_EN
    input  logic                       err_clr,
    output logic                       sel_err,
`endif
    output logic [15:0]                xfer_cnt
);
    localparam logic [SEL_W-1:0] SEL_G    = SEL_W'(NUM_REGS + SEL_G_OFS);
    localparam logic [SEL_W-1:0] SEL_IMMH = SEL_W'(NUM_REGS + SEL_IMMH_OFS);
    localparam logic [SEL_W-1:0] SEL_SEXT = SEL_W'(NUM_REGS + SEL_SEXT_OFS);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W+1)'(sel_limit(NUM_REGS));
    localparam logic [SEL_W:0]   SEL_NREG = (SEL_W+1)'(NUM_REGS);

    logic              accept;
    logic              illegal;
    logic              is_reg;
    logic [DATA_W-1:0] reg_val;
    logic [DATA_W-1:0] imm_val;
    logic [DATA_W-1:0] sel_val;
    imm_mode_e         mode;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign illegal      = {1'b0, bus.sel} >= SEL_LIM;
    assign is_reg       = {1'b0, bus.sel} < SEL_NREG;
    assign mode         = bus.sel == SEL_IMMH ? IMM_HIGH : bus.sel == SEL_SEXT ? IMM_SEXT : IMM_ZEXT;
    assign sel_val      = illegal ? '0 : is_reg ? reg_val : bus.sel == SEL_G ? greg : imm_val;

    // pick the addressed general register out of the packed register file
    always_comb begin
        reg_val = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (bus.sel == SEL_W'(k)) reg_val = regs[k*DATA_W +: DATA_W];
    end

    imm_extract #(
        .DATA_W(DATA_W),
        .IMM_W (IMM_W)
    ) u_imm (
        .ir  (ir),
        .mode(mode),
        .imm (imm_val)
    );

    // output stage: refill on accept, drain when the consumer takes an unreplaced transfer
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            xfer_cnt      <= '0;
        end else if (accept) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= sel_val;
            bus.out_sel   <= bus.sel;
            xfer_cnt      <= xfer_cnt + 16'd1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef BUS_SRC_ERR_EN
    // sticky illegal-select flag; a new illegal select outranks a same-cycle clear
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sel_err <= 1'b0;
        else if (accept && illegal) sel_err <= 1'b1;
        else if (err_clr) sel_err <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_bus_src_pipe.sv
// tb_bus_src_pipe: directed self-checking bench for bus_src_pipe with a behavioural transfer model
module tb_bus_src_pipe;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [127:0] regs = '0;
    logic [15:0]  ir = '0;
    logic [15:0]  greg = '0;
    logic [15:0]  xfer_cnt;
`ifdef BUS_SRC_ERR_EN
    logic         err_clr = 1'b0;
    logic         sel_err;
`endif
    int n_cmp = 0;
    int n_fail = 0;

    logic        m_valid;
    logic [15:0] m_data;
    logic [3:0]  m_sel;
    logic [15:0] m_cnt;
    logic        m_err;

    bus_src_pipe_if #(.DATA_W(16), .SEL_W(4)) bus ();

    bus_src_pipe dut (
        .clk     (clk),
        .resetn  (resetn),
        .regs    (regs),
        .ir      (ir),
        .greg    (greg),
        .bus     (bus),
`ifdef BUS_SRC_ERR_EN
        .err_clr (err_clr),
        .sel_err (sel_err),
`endif
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_value(input int s, input logic [127:0] r, input logic [15:0] i, input logic [15:0] g);
        int lo;
        lo = int'(i) % 512;
        if (s < 8) return r[s*16 +: 16];
        if (s == 8) return g;
        if (s == 9) return 16'(lo);
        if (s == 10) return 16'((int'(i) % 256) * 256);
        if (s == 11) return lo >= 256 ? 16'(lo - 512) : 16'(lo);
        return 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // model of the transfer stage, evaluated from the handshake rules on the sampled inputs
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sel   <= '0;
            m_cnt   <= '0;
            m_err   <= 1'b0;
        end else begin
            if (bus.in_valid && (!m_valid || bus.out_ready)) begin
                m_valid <= 1'b1;
                m_data  <= ref_value(int'(bus.sel), regs, ir, greg);
                m_sel   <= bus.sel;
                m_cnt   <= m_cnt + 16'd1;
            end else if (bus.out_ready) begin
                m_valid <= 1'b0;
            end
`ifdef BUS_SRC_ERR_EN
            if (bus.in_valid && (!m_valid || bus.out_ready) && int'(bus.sel) >= 12) m_err <= 1'b1;
            else if (err_clr) m_err <= 1'b0;
`endif
        end
    end

    // every-cycle comparison against the model, sampled mid-period
    always @(negedge clk) begin
        check("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data", 32'(bus.out_data), 32'(m_data));
        check("out_sel", 32'(bus.out_sel), 32'(m_sel));
        check("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
`ifdef BUS_SRC_ERR_EN
        check("sel_err", 32'(sel_err), 32'(m_err));
`endif
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);

        regs[3*16 +: 16] = 16'h1234;
        bus.sel = 4'd3;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("r3_valid", 32'(bus.out_valid), 32'd1);
        check("r3_data", 32'(bus.out_data), 32'h1234);
        check("r3_sel", 32'(bus.out_sel), 32'd3);
        check("r3_cnt", 32'(xfer_cnt), 32'd1);

        ir = 16'hFF85;
        bus.in_valid = 1'b1;
        bus.sel = 4'd9;
        tick();
        check("imm_zext", 32'(bus.out_data), 32'h0185);
        bus.sel = 4'd11;
        tick();
        check("imm_sext", 32'(bus.out_data), 32'hFF85);
        bus.sel = 4'd10;
        tick();
        check("imm_high", 32'(bus.out_data), 32'h8500);

        greg = 16'hBEEF;
        bus.sel = 4'd8;
        tick();
        bus.out_ready = 1'b0;
        #1;
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            greg = 16'h1111 * 16'(i + 1);
            tick();
            check("bp_data", 32'(bus.out_data), 32'hBEEF);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        greg = 16'hCAFE;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bp_refill", 32'(bus.out_data), 32'hCAFE);
        check("bp_refill_valid", 32'(bus.out_valid), 32'd1);

        bus.in_valid = 1'b1;
        bus.sel = 4'd13;
        tick();
        check("ill_data", 32'(bus.out_data), 32'h0000);
        check("ill_sel", 32'(bus.out_sel), 32'd13);
`ifdef BUS_SRC_ERR_EN
        check("ill_err", 32'(sel_err), 32'd1);
        bus.sel = 4'd14;
        err_clr = 1'b1;
        tick();
        check("ill_set_wins", 32'(sel_err), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        check("ill_clr", 32'(sel_err), 32'd0);
`endif
        bus.in_valid = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) regs[k*16 +: 16] = 16'hA000 + 16'(k * 16'h0111);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.sel = 4'(k);
            tick();
            check("b2b_valid", 32'(bus.out_valid), 32'd1);
            check("b2b_data", 32'(bus.out_data), 32'(16'hA000 + 16'(k * 16'h0111)));
        end
        bus.in_valid = 1'b0;
        tick();

        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        bus.sel = 4'd0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) tick();
        bus.in_valid = 1'b0;
        check("wrap_cnt", 32'(xfer_cnt), 32'd0);

        bus.sel = 4'd1;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_valid", 32'(bus.out_valid), 32'd0);
        check("async_cnt", 32'(xfer_cnt), 32'd0);
        tick();
        resetn = 1'b1;
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_src_pipe.md
# bus_src_pipe

Parametrised, pipelined successor to the processor's bus-source multiplexer. Selects one of NUM_REGS general registers, the G register, or an immediate field of IR onto the shared data bus. Transfers use a valid/ready handshake with a one-cycle registered output. Illegal selects and accepted transfers are tracked. Sits between the register file/IR/G and the datapath bus consumers (ALU A/B inputs, register write-back).

## Interface
- DATA_W, 16, bus and register width (even, ≥8)
- NUM_REGS, 8, general registers (≥2)
- IMM_W, 9, width of the low immediate field (≤ DATA_W)
- SEL_W, 4, select width; must satisfy 2^SEL_W ≥ NUM_REGS+4
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- regs  in  NUM_REGS*DATA_W  packed registers; register k at [k*DATA_W +: DATA_W]
- ir  in  DATA_W  instruction register
- greg  in  DATA_W  G register
- in_valid  in  1  request present
- in_ready  out  1  request accepted this cycle when high with in_valid
- sel  in  SEL_W  source select, sampled on acceptance
- out_valid  out  1  out_data holds a transfer
- out_ready  in  1  consumer takes the transfer
- out_data  out  DATA_W  selected value
- out_sel  out  SEL_W  select that produced out_data
- sel_err  out  1  sticky illegal-select flag (present only with BUS_SRC_ERR_EN)
- err_clr  in  1  clears sel_err (present only with BUS_SRC_ERR_EN)
- xfer_cnt  out  16  accepted-transfer counter, wraps

## Operation
- Select encoding, with R = NUM_REGS:
  - 0..R-1: regs[sel]
  - R: greg
  - R+1: zero-extended ir[IMM_W-1:0]
  - R+2: {ir[DATA_W/2-1:0], DATA_W/2 zeros} (load-high)
  - R+3: sign-extended ir[IMM_W-1:0]
  - ≥ R+4: illegal
- Acceptance: accept = in_valid && in_ready; in_ready = !out_valid || out_ready.
- On accept:
  - out_data is loaded with the selected value, computed from regs/ir/greg as sampled in that same cycle.
  - out_sel is loaded with sel.
  - out_valid is set to 1.
  - xfer_cnt increments modulo 2^16.
- On out_valid && out_ready without accept: out_valid is cleared. out_data and out_sel hold their last values.
- Illegal select is still accepted and counted. out_data is loaded with 0.
- Stall: while out_valid && !out_ready, out_data and out_sel are stable and in_ready is 0.
- Reset values: out_valid=0, out_data=0, out_sel=0, sel_err=0, xfer_cnt=0. in_ready=1 after reset.

## Timing
- Latency is 1 cycle: a request accepted at edge N appears on out_data after edge N.
- Throughput is 1 transfer/cycle when out_ready is held high, since drain and refill occur at the same edge.
- Changes on regs/ir/greg after acceptance do not affect the captured transfer.
- sel_err:
  - Set at the edge that accepts an illegal select.
  - Cleared at the edge where err_clr=1.
  - If set and clear happen at the same edge, set wins.
- Reset assertion mid-transfer drops out_valid immediately and asynchronously. No transfer completes, and the counter returns to 0.
- No combinational path from in_valid/sel to out_*. The only combinational path is out_ready → in_ready.

## Configuration
- BUS_SRC_ERR_EN defined:
  - sel_err/err_clr ports and logic exist.
  - Illegal selects set sel_err and output 0.
- BUS_SRC_ERR_EN undefined:
  - sel_err/err_clr ports are absent.
  - Illegal selects output 0 silently; they are still accepted and counted.

## Structure
- Package bus_src_pkg holds:
  - localparam offsets SEL_G_OFS=0, SEL_IMM_OFS=1, SEL_IMMH_OFS=2, SEL_SEXT_OFS=3 (added to NUM_REGS)
  - a function returning the illegal-select threshold for a given NUM_REGS
- Sub-module imm_extract (combinational) takes ir and mode and returns the zero-ext, load-high or sign-ext value. It is parametrised by DATA_W and IMM_W.
- Top level contains the register select, the output pipeline register, the error flag and the counter.

## Test plan
All scenarios use default parameters.
- Reset then R3=16'h1234, sel=3, in_valid=1, out_ready=1 → one cycle later out_valid=1, out_data=16'h1234, out_sel=3, xfer_cnt=1.
- ir=16'hFF85, sel=9 → out_data=16'h0185; sel=11 → 16'hFF85; sel=10 → 16'h8500.
- Backpressure: accept greg=16'hBEEF, hold out_ready=0 for 3 cycles while greg changes and in_valid stays 1 → in_ready=0, out_data stays 16'hBEEF; on out_ready=1 the next request is accepted at the same edge.
- Illegal sel=13 → out_data=0, sel_err=1, xfer_cnt increments. err_clr=1 together with another sel=14 → sel_err stays 1. err_clr alone → sel_err=0.
- Back-to-back sels 0..7 with out_ready=1 → 8 consecutive out_valid cycles with matching data. 65536 transfers → xfer_cnt wraps to 0.
- resetn pulsed low while out_valid=1 and out_ready=0 → out_valid=0 and xfer_cnt=0 immediately; in_ready=1 after release.
